xor_hamming_acc: RTL and testbench

Downstream consumer of the 16-bit bitwise XOR stage. It accepts a stream of XOR result words (a ^ b) over a valid/ready handshake, counts the set bits in each word, and accumulates the counts over a fixed-length frame. The output is the per-frame Hamming distance between the two XOR operand streams, with a saturation flag. It sits between the XOR array and the comparison/statistics logic that reads frame error totals.

---
 rtl/xor_hamming_acc.sv | 105 ++++++++++
 tb/tb_xor_hamming_acc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/xor_hamming_acc.sv
// Per-frame Hamming distance: popcount each XOR word, saturating sum over FRAME_LEN words; result 2 edges after last accept.
// in_ready depends only on state; it is low from the last accept until the result is taken, and the result is held while out_ready=0.
module xor_hamming_acc #(
   parameter int N         = 16,
   parameter int FRAME_LEN = 8,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   output logic          out_sat,
   output logic          busy
);
   localparam int PW = $clog2(N + 1);
   localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [WW-1:0] LAST_W  = WW'(FRAME_LEN - 1);
   localparam logic [CW:0]   SAT_MAX = {1'b0, {CW{1'b1}}};

   typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wcnt;
   logic [PW-1:0] pc_reg, pc_nxt;
   logic          pc_vld;
   logic [CW-1:0] acc;
   logic          sat_flag;
   logic          take, last_word, overflow;
   logic [CW:0]   sum;
   logic [CW-1:0] sum_sat;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   // A word presented alongside clear is dropped, not counted into the next frame.
   assign take      = in_valid && in_ready && !clear;
   assign last_word = (wcnt == LAST_W);
   assign sum       = {1'b0, acc} + (CW + 1)'(pc_reg);
   assign overflow  = (sum > SAT_MAX);
   assign sum_sat   = overflow ? {CW{1'b1}} : sum[CW-1:0];
   assign busy      = (wcnt != '0) | pc_vld | (state != ACCUM);

   always_comb begin
      pc_nxt = '0;
      for (int i = 0; i < N; i++) begin
         pc_nxt = pc_nxt + PW'(in_data[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (take && last_word) state_nxt = FLUSH;
         FLUSH:   state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
      if (clear) state_nxt = ACCUM;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt      <= '0;
         pc_reg    <= '0;
         pc_vld    <= 1'b0;
         acc       <= '0;
         sat_flag  <= 1'b0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else if (clear) begin
         wcnt     <= '0;
         pc_vld   <= 1'b0;
         acc      <= '0;
         sat_flag <= 1'b0;
      end else begin
         pc_vld <= take;
         if (take) begin
            pc_reg <= pc_nxt;
            wcnt   <= last_word ? '0 : wcnt + WW'(1);
         end
         // FLUSH folds the final popcount straight into the result and restarts the accumulator.
         if (state == FLUSH) begin
            out_count <= sum_sat;
            out_sat   <= sat_flag | overflow;
            acc       <= '0;
            sat_flag  <= 1'b0;
         end else if (pc_vld) begin
            acc      <= sum_sat;
            sat_flag <= sat_flag | overflow;
         end
      end
   end
endmodule

// File: tb/tb_xor_hamming_acc.sv
// Directed bench: four instances (FRAME_LEN 2/8/4, and CW=4 FRAME_LEN=4) share stimulus; each group checks one instance after a common reset.
module tb_xor_hamming_acc;
   logic        clk = 1'b0;
   logic        rst, clear, in_valid, out_ready;
   logic [15:0] in_data;

   logic        r2, v2, s2, b2;
   logic [15:0] c2;
   logic        r8, v8, s8, b8;
   logic [15:0] c8;
   logic        r4, v4, s4, b4;
   logic [15:0] c4;
   logic        rs, vs, ss, bs;
   logic [3:0]  cs;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xor_hamming_acc #(.N(16), .FRAME_LEN(2), .CW(16)) d2 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r2),
      .in_data(in_data), .out_valid(v2), .out_ready(out_ready), .out_count(c2),
      .out_sat(s2), .busy(b2));
   xor_hamming_acc #(.N(16), .FRAME_LEN(8), .CW(16)) d8 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r8),
      .in_data(in_data), .out_valid(v8), .out_ready(out_ready), .out_count(c8),
      .out_sat(s8), .busy(b8));
   xor_hamming_acc #(.N(16), .FRAME_LEN(4), .CW(16)) d4 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r4),
      .in_data(in_data), .out_valid(v4), .out_ready(out_ready), .out_count(c4),
      .out_sat(s4), .busy(b4));
   xor_hamming_acc #(.N(16), .FRAME_LEN(4), .CW(4)) ds (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rs),
      .in_data(in_data), .out_valid(vs), .out_ready(out_ready), .out_count(cs),
      .out_sat(ss), .busy(bs));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [15:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
   endtask

   initial begin
      // Reset held 2 cycles while a word is offered
      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 16'hffff; out_ready = 1'b1;
      tick(); tick();
      check("rst_in_ready", 32'(r8), 32'd1);
      check("rst_out_valid", 32'(v8), 32'd0);
      check("rst_out_count", 32'(c8), 32'd0);
      check("rst_out_sat", 32'(s8), 32'd0);
      check("rst_busy", 32'(b8), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("rst_no_word_busy", 32'(b8), 32'd0);

      // Basic frame, FRAME_LEN=2: popcounts 8 + 8
      do_reset();
      send(16'ha555);
      check("basic_mid_in_ready", 32'(r2), 32'd1);
      send(16'h3c3c);
      in_valid = 1'b0;
      check("basic_k_in_ready", 32'(r2), 32'd0);
      check("basic_k_out_valid", 32'(v2), 32'd0);
      tick();
      check("basic_k1_out_valid", 32'(v2), 32'd1);
      check("basic_k1_in_ready", 32'(r2), 32'd0);
      check("basic_count", 32'(c2), 32'd16);
      check("basic_sat", 32'(s2), 32'd0);
      tick();
      check("basic_k2_out_valid", 32'(v2), 32'd0);
      check("basic_k2_in_ready", 32'(r2), 32'd1);
      check("basic_k2_busy", 32'(b2), 32'd0);

      // Backpressure, FRAME_LEN=8: eight 0xffff, result stalled 5 cycles
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(16'hffff);
      check("bp_flush_in_ready", 32'(r8), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_out_valid", 32'(v8), 32'd1);
         check("bp_hold_count", 32'(c8), 32'd128);
         check("bp_hold_in_ready", 32'(r8), 32'd0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", 32'(v8), 32'd0);
      check("bp_release_busy", 32'(b8), 32'd0);
      for (int i = 0; i < 8; i++) send(16'h0001);
      in_valid = 1'b0;
      tick();
      check("bp_next_count", 32'(c8), 32'd8);
      check("bp_next_out_valid", 32'(v8), 32'd1);

      // Saturation, CW=4: 1+8+8+0 clamps at 15
      do_reset();
      send(16'h0001); send(16'h00ff); send(16'h00ff); send(16'h0000);
      in_valid = 1'b0;
      tick();
      check("sat_out_valid", 32'(vs), 32'd1);
      check("sat_count", 32'(cs), 32'd15);
      check("sat_flag", 32'(ss), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) send(16'h0001);
      in_valid = 1'b0;
      tick();
      check("sat_next_count", 32'(cs), 32'd4);
      check("sat_next_flag", 32'(ss), 32'd0);

      // Gapped input, FRAME_LEN=4: four 0x000f with idle cycles between
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(16'h000f);
         in_valid = 1'b0;
         tick();
      end
      check("gap_out_valid", 32'(v4), 32'd1);
      check("gap_count", 32'(c4), 32'd16);
      tick();

      // Clear after 2 words; the word offered with clear is dropped
      send(16'h00ff); send(16'h00ff);
      clear = 1'b1; in_valid = 1'b1; in_data = 16'hffff;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      check("clear_busy", 32'(b4), 32'd0);
      check("clear_in_ready", 32'(r4), 32'd1);
      for (int i = 0; i < 4; i++) send(16'h0003);
      in_valid = 1'b0;
      tick();
      check("clear_count", 32'(c4), 32'd8);
      check("clear_sat", 32'(s4), 32'd0);
      tick();

      // Reset while a result is being held
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'hffff);
      in_valid = 1'b0;
      tick();
      check("hold_out_valid", 32'(v4), 32'd1);
      check("hold_count", 32'(c4), 32'd64);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hold_rst_out_valid", 32'(v4), 32'd0);
      check("hold_rst_count", 32'(c4), 32'd0);
      check("hold_rst_in_ready", 32'(r4), 32'd1);
      check("hold_rst_busy", 32'(b4), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
